// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame decoder: FSM encoding, default
// start-of-frame marker and the checksum width rule.
package uart_pkg;

  typedef enum logic [3:0] {
    HUNT = 4'b0001,
    LEN  = 4'b0010,
    DATA = 4'b0100,
    CSUM = 4'b1000
  } frame_state_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // The running checksum is exactly one data word wide and wraps modulo 2^width.
  function automatic int csum_width(input int dlen);
    return dlen;
  endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// Frame decoder behind the UART receiver: hunts for SOF, parses LEN, payload
// and CSUM, and streams the payload out with tlast/tuser and status pulses.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int              DLEN = 8,
  parameter logic [DLEN-1:0] SOF  = DLEN'(SOF_DEFAULT)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_tvalid,
  output logic            o_tready,
  input  logic [DLEN-1:0] i_tdata,
  output logic            o_tvalid,
  input  logic            i_tready,
  output logic [DLEN-1:0] o_tdata,
  output logic            o_tlast,
  output logic            o_tuser,
  output logic            o_frame_ok,
  output logic            o_frame_err
);

  localparam int CW = csum_width(DLEN);

  frame_state_e    state_q;
  logic [DLEN-1:0] hold_q;
  logic            hold_vld_q;
  logic [CW-1:0]   sum_q;
  logic [CW-1:0]   sum_d;
  logic [7:0]      count_q;
  logic            o_tvalid_q;
  logic [DLEN-1:0] o_tdata_q;
  logic            o_tlast_q;
  logic            o_tuser_q;
  logic            frame_ok_q;
  logic            frame_err_q;
  logic            slot_free_s;
  logic            in_xfer_s;

  // Acceptance depends only on state, hold occupancy and output-slot availability.
  always_comb begin
    slot_free_s = !o_tvalid_q || i_tready;
    case (state_q)
      HUNT:    o_tready = 1'b1;
      LEN:     o_tready = 1'b1;
      DATA:    o_tready = !hold_vld_q || slot_free_s;
      CSUM:    o_tready = slot_free_s;
      default: o_tready = 1'b0;
    endcase
    in_xfer_s = i_tvalid && o_tready;
    sum_d     = sum_q + CW'(i_tdata);
  end

  // Frame parser, hold register and output register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= HUNT;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      sum_q       <= '0;
      count_q     <= 8'd0;
      o_tvalid_q  <= 1'b0;
      o_tdata_q   <= '0;
      o_tlast_q   <= 1'b0;
      o_tuser_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (o_tvalid_q && i_tready) begin
        o_tvalid_q <= 1'b0;
      end
      if (in_xfer_s) begin
        case (state_q)
          HUNT: begin
            if (i_tdata == SOF) begin
              state_q <= LEN;
            end
          end
          LEN: begin
            if (i_tdata == '0) begin
              frame_err_q <= 1'b1;
              state_q     <= HUNT;
            end else begin
              count_q <= 8'(i_tdata);
              sum_q   <= CW'(i_tdata);
              state_q <= DATA;
            end
          end
          DATA: begin
            sum_q   <= sum_d;
            count_q <= count_q - 8'd1;
            // The previous payload byte is now known not to be the last one.
            if (hold_vld_q) begin
              o_tvalid_q <= 1'b1;
              o_tdata_q  <= hold_q;
              o_tlast_q  <= 1'b0;
              o_tuser_q  <= 1'b0;
            end
            hold_q     <= i_tdata;
            hold_vld_q <= 1'b1;
            if (count_q == 8'd1) begin
              state_q <= CSUM;
            end
          end
          CSUM: begin
            o_tvalid_q  <= 1'b1;
            o_tdata_q   <= hold_q;
            o_tlast_q   <= 1'b1;
            o_tuser_q   <= (sum_d != '0);
            hold_vld_q  <= 1'b0;
            frame_ok_q  <= (sum_d == '0);
            frame_err_q <= (sum_d != '0);
            state_q     <= HUNT;
          end
          default: begin
            state_q    <= HUNT;
            hold_vld_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_tvalid    = o_tvalid_q;
  assign o_tdata     = o_tdata_q;
  assign o_tlast     = o_tlast_q;
  assign o_tuser     = o_tuser_q;
  assign o_frame_ok  = frame_ok_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed frames plus randomized
// streams compared against a frame-level reference parser.
module tb_uart_frame_rx;

  localparam int         DLEN = 8;
  localparam logic [7:0] SOF  = 8'hA5;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_tvalid = 1'b0;
  logic [7:0] i_tdata = 8'h00;
  logic       i_tready = 1'b1;
  logic       o_tready, o_tvalid, o_tlast, o_tuser, o_frame_ok, o_frame_err;
  logic [7:0] o_tdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  logic [7:0] stream_q[$];
  int got_ok = 0, got_err = 0, misaligned = 0, cyc_cnt = 0;
  int exp_ok, exp_err;

  uart_frame_rx #(.DLEN(DLEN), .SOF(SOF)) dut (
    .clk(clk), .rstn(rstn),
    .i_tvalid(i_tvalid), .o_tready(o_tready), .i_tdata(i_tdata),
    .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tdata(o_tdata),
    .o_tlast(o_tlast), .o_tuser(o_tuser),
    .o_frame_ok(o_frame_ok), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Capture output transfers and status pulses between clock edges.
  always @(negedge clk) begin
    if (rstn) begin
      if (o_tvalid && i_tready) got_q.push_back({o_tuser, o_tlast, o_tdata});
      if (o_frame_ok) begin
        got_ok++;
        if (!(o_tvalid && o_tlast && !o_tuser)) misaligned++;
      end
      if (o_frame_err) got_err++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference: parse stream_q as SOF, LEN, payload, CSUM frames.
  task automatic model_stream();
    int i = 0;
    int n = stream_q.size();
    int len;
    logic [7:0] sum;
    bit bad;
    exp_q.delete();
    exp_ok = 0;
    exp_err = 0;
    while (i < n) begin
      if (stream_q[i] != SOF) begin
        i++;
      end else if (i + 1 >= n) begin
        i = n;
      end else begin
        len = int'(stream_q[i+1]);
        if (len == 0) begin
          exp_err++;
          i += 2;
        end else if (i + 2 + len >= n) begin
          i = n;
        end else begin
          sum = 8'(len);
          for (int k = 0; k <= len; k++) sum = sum + stream_q[i+2+k];
          bad = (sum != 8'd0);
          for (int k = 0; k < len; k++)
            exp_q.push_back({bad && (k == len-1), (k == len-1), stream_q[i+2+k]});
          if (bad) exp_err++; else exp_ok++;
          i += 3 + len;
        end
      end
    end
  endtask

  task automatic add_frame(input int len, input bit bad);
    logic [7:0] s, b;
    s = 8'(len);
    stream_q.push_back(SOF);
    stream_q.push_back(8'(len));
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      stream_q.push_back(b);
      s = s + b;
    end
    b = 8'd0 - s;
    if (bad) b = b + 8'($urandom_range(1, 255));
    stream_q.push_back(b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int cyc = 0;
    i_tvalid = 1'b1;
    i_tdata  = b;
    @(negedge clk);
    while (!o_tready && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    if (!o_tready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: byte %02h not accepted after %0d cycles, required acceptance", b, cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_stream();
    foreach (stream_q[k]) send_byte(stream_q[k]);
    i_tvalid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    i_tvalid = 1'b1;
    i_tdata = 8'(SOF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({o_tvalid, o_tlast, o_tuser, o_frame_ok, o_frame_err, o_tdata} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v%b l%b u%b ok%b err%b d%02h, required all zero",
               o_tvalid, o_tlast, o_tuser, o_frame_ok, o_frame_err, o_tdata);
    end
    n_checks++;
    if (o_tready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b, required 1", o_tready);
    end
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame();
    int base = got_q.size();
    int ok0 = got_ok, err0 = got_err, mis0 = misaligned;
    stream_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    model_stream();
    i_tready = 1'b1;
    run_stream();
    n_checks++;
    if (got_q.size() - base !== exp_q.size()) begin
      n_fail++; $display("FAIL good_count: got %0d beats, required %0d", got_q.size() - base, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) if (base + k < got_q.size()) begin
      n_checks++;
      if (got_q[base+k] !== exp_q[k]) begin
        n_fail++; $display("FAIL good_beat[%0d]: got %03h, required %03h", k, got_q[base+k], exp_q[k]);
      end
    end
    if (got_q.size() - base == 3) begin
      n_checks++;
      if (got_q[base+2] !== 10'h133) begin
        n_fail++; $display("FAIL good_last: got %03h, required 133", got_q[base+2]);
      end
    end
    n_checks++;
    if (got_ok - ok0 !== 1 || got_err - err0 !== 0) begin
      n_fail++; $display("FAIL good_pulses: got ok=%0d err=%0d, required ok=1 err=0", got_ok - ok0, got_err - err0);
    end
    n_checks++;
    if (misaligned - mis0 !== 0) begin
      n_fail++; $display("FAIL good_pulse_align: got %0d misaligned, required 0", misaligned - mis0);
    end
  endtask

  task automatic test_bad_checksum();
    int base = got_q.size();
    int ok0 = got_ok, err0 = got_err;
    stream_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    model_stream();
    run_stream();
    n_checks++;
    if (got_q.size() - base !== 3) begin
      n_fail++; $display("FAIL bad_count: got %0d beats, required 3", got_q.size() - base);
    end
    for (int k = 0; k < exp_q.size(); k++) if (base + k < got_q.size()) begin
      n_checks++;
      if (got_q[base+k] !== exp_q[k]) begin
        n_fail++; $display("FAIL bad_beat[%0d]: got %03h, required %03h", k, got_q[base+k], exp_q[k]);
      end
    end
    if (got_q.size() - base == 3) begin
      n_checks++;
      if (got_q[base+2] !== 10'h333) begin
        n_fail++; $display("FAIL bad_last: got %03h, required 333", got_q[base+2]);
      end
    end
    n_checks++;
    if (got_ok - ok0 !== 0 || got_err - err0 !== 1) begin
      n_fail++; $display("FAIL bad_pulses: got ok=%0d err=%0d, required ok=0 err=1", got_ok - ok0, got_err - err0);
    end
  endtask

  task automatic test_garbage_zero_len();
    int base = got_q.size();
    int ok0 = got_ok, err0 = got_err;
    stream_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'hA5, 8'h01, 8'h7E, 8'h81};
    model_stream();
    run_stream();
    n_checks++;
    if (got_q.size() - base !== 1) begin
      n_fail++; $display("FAIL zlen_count: got %0d beats, required 1", got_q.size() - base);
    end else begin
      n_checks++;
      if (got_q[base] !== 10'h17E || exp_q[0] !== 10'h17E) begin
        n_fail++; $display("FAIL zlen_beat: got %03h, required 17E", got_q[base]);
      end
    end
    n_checks++;
    if (got_ok - ok0 !== exp_ok || got_err - err0 !== exp_err) begin
      n_fail++; $display("FAIL zlen_pulses: got ok=%0d err=%0d, required ok=%0d err=%0d",
                         got_ok - ok0, got_err - err0, exp_ok, exp_err);
    end
  endtask

  task automatic test_backpressure();
    int base = got_q.size();
    int ok0 = got_ok;
    int waited = 0;
    bit saw_stall = 1'b0;
    stream_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    model_stream();
    i_tready = 1'b0;
    fork
      run_stream();
      begin
        @(negedge clk);
        while (!o_tvalid && waited < 100) begin
          waited++;
          @(negedge clk);
        end
        for (int c = 0; c < 10; c++) begin
          n_checks++;
          if (o_tvalid !== 1'b1 || o_tdata !== 8'h11) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got v%b d%02h, required v1 d11", c, o_tvalid, o_tdata);
          end
          if (!o_tready) saw_stall = 1'b1;
          @(negedge clk);
        end
        @(posedge clk); #1;
        i_tready = 1'b1;
      end
    join
    n_checks++;
    if (!saw_stall) begin
      n_fail++; $display("FAIL bp_stall: got o_tready never low, required a stall");
    end
    n_checks++;
    if (got_q.size() - base !== exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d beats, required %0d", got_q.size() - base, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) if (base + k < got_q.size()) begin
      n_checks++;
      if (got_q[base+k] !== exp_q[k]) begin
        n_fail++; $display("FAIL bp_beat[%0d]: got %03h, required %03h", k, got_q[base+k], exp_q[k]);
      end
    end
    n_checks++;
    if (got_ok - ok0 !== 1) begin
      n_fail++; $display("FAIL bp_ok: got %0d, required 1", got_ok - ok0);
    end
  endtask

  task automatic test_back_to_back();
    int base = got_q.size();
    int ok0 = got_ok;
    int c0, c1;
    stream_q.delete();
    add_frame(3, 1'b0);
    add_frame(3, 1'b0);
    model_stream();
    i_tready = 1'b1;
    c0 = cyc_cnt;
    foreach (stream_q[k]) send_byte(stream_q[k]);
    c1 = cyc_cnt;
    i_tvalid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (c1 - c0 !== stream_q.size()) begin
      n_fail++; $display("FAIL b2b_rate: got %0d cycles, required %0d", c1 - c0, stream_q.size());
    end
    n_checks++;
    if (got_q.size() - base !== 6) begin
      n_fail++; $display("FAIL b2b_count: got %0d beats, required 6", got_q.size() - base);
    end
    for (int k = 0; k < exp_q.size(); k++) if (base + k < got_q.size()) begin
      n_checks++;
      if (got_q[base+k] !== exp_q[k]) begin
        n_fail++; $display("FAIL b2b_beat[%0d]: got %03h, required %03h", k, got_q[base+k], exp_q[k]);
      end
    end
    n_checks++;
    if (got_ok - ok0 !== 2) begin
      n_fail++; $display("FAIL b2b_ok: got %0d, required 2", got_ok - ok0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base = got_q.size();
    int ok0 = got_ok, err0 = got_err;
    i_tready = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    i_tvalid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    i_tready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_tvalid !== 1'b0 || o_tready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_state: got v%b rdy%b, required v0 rdy1", o_tvalid, o_tready);
    end
    @(posedge clk); #1;
    stream_q.delete();
    add_frame($urandom_range(1, 5), 1'b0);
    model_stream();
    run_stream();
    n_checks++;
    if (got_q.size() - base !== exp_q.size()) begin
      n_fail++; $display("FAIL rst_mid_count: got %0d beats, required %0d", got_q.size() - base, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) if (base + k < got_q.size()) begin
      n_checks++;
      if (got_q[base+k] !== exp_q[k]) begin
        n_fail++; $display("FAIL rst_mid_beat[%0d]: got %03h, required %03h", k, got_q[base+k], exp_q[k]);
      end
    end
    n_checks++;
    if (got_ok - ok0 !== 1 || got_err - err0 !== 0) begin
      n_fail++; $display("FAIL rst_mid_pulses: got ok=%0d err=%0d, required ok=1 err=0", got_ok - ok0, got_err - err0);
    end
  endtask

  task automatic test_random();
    int base = got_q.size();
    int ok0 = got_ok, err0 = got_err, mis0 = misaligned;
    bit done = 1'b0;
    int r;
    logic [7:0] b;
    stream_q.delete();
    repeat (20) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        b = 8'($urandom);
        if (b == SOF) b = 8'h00;
        stream_q.push_back(b);
      end else if (r == 2) begin
        stream_q.push_back(SOF);
        stream_q.push_back(8'h00);
      end else begin
        add_frame($urandom_range(1, 6), ($urandom_range(0, 3) == 0));
      end
    end
    model_stream();
    fork
      begin
        run_stream();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          i_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    i_tready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() - base !== exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d beats, required %0d", got_q.size() - base, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) if (base + k < got_q.size()) begin
      n_checks++;
      if (got_q[base+k] !== exp_q[k]) begin
        n_fail++; $display("FAIL rand_beat[%0d]: got %03h, required %03h", k, got_q[base+k], exp_q[k]);
      end
    end
    n_checks++;
    if (got_ok - ok0 !== exp_ok || got_err - err0 !== exp_err) begin
      n_fail++; $display("FAIL rand_pulses: got ok=%0d err=%0d, required ok=%0d err=%0d",
                         got_ok - ok0, got_err - err0, exp_ok, exp_err);
    end
    n_checks++;
    if (misaligned - mis0 !== 0) begin
      n_fail++; $display("FAIL rand_pulse_align: got %0d misaligned, required 0", misaligned - mis0);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_garbage_zero_len();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
